// File: rtl/lsq_pkg.sv
// Shared types and default widths for the in-order load/store queue.
//   LSQ_*        default address/data/control/tag widths and queue depth
//   lsq_entry_t  one queued memory op at the default widths
//   lsq_entry_width()  packed width of an entry for arbitrary widths
package lsq_pkg;

    localparam int unsigned LSQ_AW    = 32;
    localparam int unsigned LSQ_DW    = 32;
    localparam int unsigned LSQ_CW    = 16;
    localparam int unsigned LSQ_ZW    = 4;
    localparam int unsigned LSQ_DEPTH = 16;

    typedef struct packed {
        logic              rw;     // 1 = store, 0 = load
        logic [LSQ_AW-1:0] addr;
        logic [LSQ_DW-1:0] data;
        logic [LSQ_CW-1:0] cntrl;
        logic [LSQ_ZW-1:0] z;
    } lsq_entry_t;

    function automatic int unsigned lsq_entry_width(int unsigned aw, int unsigned dw,
                                                    int unsigned cw, int unsigned zw);
        return 1 + aw + dw + cw + zw;
    endfunction

endpackage

// File: rtl/lsq_inorder_buffer_if.sv
// Bus bundle of the in-order LSQ: Ex/Mem enqueue side, data-cache side, Mem/Wb result side.
//   slave  : view of the queue itself
//   master : view of the surrounding pipeline / cache / testbench
interface lsq_inorder_buffer_if #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned CW    = 16,
    parameter int unsigned ZW    = 4,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    // Enqueue side
    logic          in_valid;
    logic          in_ready;
    logic          in_rw;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_cntrl;
    logic [ZW-1:0] in_z;
    logic          stall_out;
    // Cache side
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    // Result side
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] data_out;
    logic [CW-1:0] cntrl_out;
    logic [ZW-1:0] z_out;
    logic [CntW-1:0] count_out;

    modport slave (
        input  in_valid, in_rw, in_addr, in_data, in_cntrl, in_z, mem_rdata, out_ready,
        output in_ready, stall_out, mem_rw, mem_addr, mem_wdata,
        output out_valid, data_out, cntrl_out, z_out, count_out
    );

    modport master (
        output in_valid, in_rw, in_addr, in_data, in_cntrl, in_z, mem_rdata, out_ready,
        input  in_ready, stall_out, mem_rw, mem_addr, mem_wdata,
        input  out_valid, data_out, cntrl_out, z_out, count_out
    );

endinterface

// File: rtl/lsq_ring_ram.sv
// Circular-buffer storage for the LSQ: one synchronous write port, one asynchronous read port.
//   clk    clock
//   we     write enable
//   waddr  write index (tail)
//   wdata  entry to write
//   raddr  read index (head)
//   rdata  entry at raddr, combinational
module lsq_ring_ram #(
    parameter int unsigned Width = 85,
    parameter int unsigned Depth = 16,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [Width-1:0] wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem [Depth];

    // Contents are not reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lsq_inorder_buffer.sv
// In-order load/store queue between Ex/Mem and Mem/Wb.
// Buffers up to DEPTH ops, issues the oldest to a combinational-read data cache and holds the
// result (load data or 0 for stores, plus cntrl/z) in a valid/ready output register.
//   clk    clock, rising edge
//   rst    asynchronous active-low reset
//   flush  synchronous clear of the queue and the output register
//   bus    lsq_inorder_buffer_if.slave: enqueue, cache and result signals
module lsq_inorder_buffer
    import lsq_pkg::*;
#(
    parameter int unsigned AW    = LSQ_AW,
    parameter int unsigned DW    = LSQ_DW,
    parameter int unsigned CW    = LSQ_CW,
    parameter int unsigned ZW    = LSQ_ZW,
    parameter int unsigned DEPTH = LSQ_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    lsq_inorder_buffer_if.slave bus
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CntW   = $clog2(DEPTH + 1);
    localparam int unsigned EntryW = lsq_entry_width(AW, DW, CW, ZW);

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [CW-1:0] cntrl;
        logic [ZW-1:0] z;
    } entry_t;

    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   data_q, data_d;
    logic [CW-1:0]   cntrl_q, cntrl_d;
    logic [ZW-1:0]   z_q, z_d;

    logic   in_ready, enq, issue;
    entry_t in_entry, head_entry;

    assign in_entry = '{rw: bus.in_rw, addr: bus.in_addr, data: bus.in_data,
                        cntrl: bus.in_cntrl, z: bus.in_z};

    lsq_ring_ram #(
        .Width (EntryW),
        .Depth (DEPTH)
    ) u_ring_ram (
        .clk   (clk),
        .we    (enq),
        .waddr (tail_q),
        .wdata (in_entry),
        .raddr (head_q),
        .rdata (head_entry)
    );

    always_comb begin
        // Full refuses input even if a slot frees this cycle: no pass-through path.
        in_ready = (count_q != CntW'(DEPTH));
        enq      = bus.in_valid && in_ready && !flush;
        issue    = (count_q != '0) && (!out_valid_q || bus.out_ready) && !flush;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq)   tail_d = tail_q + PtrW'(1);
            if (issue) head_d = head_q + PtrW'(1);
            count_d = count_q + CntW'(enq) - CntW'(issue);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        data_d      = data_q;
        cntrl_d     = cntrl_q;
        z_d         = z_q;
        if (flush) begin
            out_valid_d = 1'b0;
            data_d      = '0;
            cntrl_d     = '0;
            z_d         = '0;
        end else if (issue) begin
            out_valid_d = 1'b1;
            data_d      = head_entry.rw ? '0 : bus.mem_rdata;
            cntrl_d     = head_entry.cntrl;
            z_d         = head_entry.z;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            cntrl_q     <= '0;
            z_q         <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            cntrl_q     <= cntrl_d;
            z_q         <= z_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.stall_out = !in_ready;
    assign bus.mem_rw    = issue && head_entry.rw;
    assign bus.mem_addr  = head_entry.addr;
    assign bus.mem_wdata = head_entry.data;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_q;
    assign bus.cntrl_out = cntrl_q;
    assign bus.z_out     = z_q;
    assign bus.count_out = count_q;

endmodule

// File: tb/tb_lsq_inorder_buffer.sv
module tb_lsq_inorder_buffer;
    import lsq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    lsq_inorder_buffer_if #(
        .AW(32), .DW(32), .CW(16), .ZW(4), .DEPTH(16)
    ) bus ();

    lsq_inorder_buffer #(
        .AW(32), .DW(32), .CW(16), .ZW(4), .DEPTH(16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    // Single-cycle data cache: combinational read, write on the rising edge.
    logic [31:0] cache [0:255];
    assign bus.mem_rdata = cache[bus.mem_addr[9:2]];
    always @(posedge clk) begin
        if (bus.mem_rw) cache[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end

    // Reference memory and expected-response scoreboard.
    typedef struct packed {
        logic [31:0] data;
        logic [15:0] cntrl;
        logic [3:0]  z;
    } resp_t;

    logic [31:0] model_mem [0:255];
    resp_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;
    int          n_resp   = 0;

    typedef struct {
        logic        in_valid;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] cntrl;
        logic [3:0]  z;
        logic        out_ready;
        logic        exp_mem_rw;
        logic        exp_ov;
        logic [31:0] exp_data;
        logic [15:0] exp_cntrl;
        logic [3:0]  exp_z;
        logic [4:0]  exp_cnt;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic v, input logic rw, input logic [31:0] a,
                            input logic [31:0] d, input logic [15:0] c, input logic [3:0] z);
        bus.in_valid = v;
        bus.in_rw    = rw;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.in_cntrl = c;
        bus.in_z     = z;
    endtask

    // Called at posedge+1 with inputs already driven; models handshakes, then advances one edge.
    task automatic cycle();
        resp_t r;
        resp_t e;
        #1;
        if (bus.in_valid && bus.in_ready && !flush) begin
            r.cntrl = bus.in_cntrl;
            r.z     = bus.in_z;
            if (bus.in_rw) begin
                model_mem[bus.in_addr[9:2]] = bus.in_data;
                r.data = '0;
            end else begin
                r.data = model_mem[bus.in_addr[9:2]];
            end
            exp_q.push_back(r);
            n_acc++;
        end
        if (bus.out_valid && bus.out_ready) begin
            n_resp++;
            if (exp_q.size() == 0) begin
                check("unexpected_response", 32'(bus.z_out), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("resp%0d_data", n_resp), bus.data_out, e.data);
                check($sformatf("resp%0d_cntrl", n_resp), 32'(bus.cntrl_out), 32'(e.cntrl));
                check($sformatf("resp%0d_z", n_resp), 32'(bus.z_out), 32'(e.z));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        drive_op(1'b0, 1'b0, '0, '0, '0, '0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200 && (exp_q.size() != 0 || bus.out_valid); i++) cycle();
        check({tag, "_drain_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_drain_count"}, 32'(bus.count_out), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_count"}, 32'(bus.count_out), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_stall"}, 32'(bus.stall_out), 32'd0);
        check({tag, "_mem_rw"}, 32'(bus.mem_rw), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
        $fatal(1);
    end

    initial begin
        int acc0;
        int k;
        for (int i = 0; i < 256; i++) begin
            cache[i]     = '0;
            model_mem[i] = '0;
        end

        // Hand-computed single-step vectors; queue starts empty.
        //            v  rw addr      data          cntrl     z   ordy mrw ov exp_data      ecntrl    ez  cnt
        vecs[0] = '{1, 1, 32'h40, 32'hDEADBEEF, 16'h0011, 4'd1, 1, 0, 0, 32'h0,        16'h0,    4'd0, 5'd1};
        vecs[1] = '{1, 0, 32'h40, 32'h0,        16'h0022, 4'd2, 1, 1, 1, 32'h0,        16'h0011, 4'd1, 5'd1};
        vecs[2] = '{1, 1, 32'h44, 32'h12345678, 16'h0033, 4'd3, 1, 0, 1, 32'hDEADBEEF, 16'h0022, 4'd2, 5'd1};
        vecs[3] = '{1, 0, 32'h44, 32'h0,        16'h0044, 4'd4, 1, 1, 1, 32'h0,        16'h0033, 4'd3, 5'd1};
        vecs[4] = '{0, 0, 32'h0,  32'h0,        16'h0,    4'd0, 0, 0, 1, 32'h0,        16'h0033, 4'd3, 5'd1};
        vecs[5] = '{0, 0, 32'h0,  32'h0,        16'h0,    4'd0, 1, 0, 1, 32'h12345678, 16'h0044, 4'd4, 5'd0};
        vecs[6] = '{0, 0, 32'h0,  32'h0,        16'h0,    4'd0, 1, 0, 0, 32'h0,        16'h0,    4'd0, 5'd0};
        vecs[7] = '{1, 0, 32'h40, 32'h0,        16'h0055, 4'd5, 0, 0, 0, 32'h0,        16'h0,    4'd0, 5'd1};
        vecs[8] = '{0, 0, 32'h0,  32'h0,        16'h0,    4'd0, 0, 0, 1, 32'hDEADBEEF, 16'h0055, 4'd5, 5'd0};

        rst   = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive_op(1'b0, 1'b0, '0, '0, '0, '0);
        #3;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Store/load table
        for (int i = 0; i < 9; i++) begin
            drive_op(vecs[i].in_valid, vecs[i].rw, vecs[i].addr, vecs[i].data,
                     vecs[i].cntrl, vecs[i].z);
            bus.out_ready = vecs[i].out_ready;
            #1;
            check($sformatf("tbl%0d_mem_rw", i), 32'(bus.mem_rw), 32'(vecs[i].exp_mem_rw));
            if (vecs[i].in_valid && vecs[i].rw) model_mem[vecs[i].addr[9:2]] = vecs[i].data;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_count", i), 32'(bus.count_out), 32'(vecs[i].exp_cnt));
            check($sformatf("tbl%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_ov));
            if (vecs[i].exp_ov) begin
                check($sformatf("tbl%0d_data", i), bus.data_out, vecs[i].exp_data);
                check($sformatf("tbl%0d_cntrl", i), 32'(bus.cntrl_out), 32'(vecs[i].exp_cntrl));
                check($sformatf("tbl%0d_z", i), 32'(bus.z_out), 32'(vecs[i].exp_z));
            end
        end
        // Release the pending load from vector 8 without scoreboarding it.
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Full: 20 offered with out_ready low, 17 fit (16 queued + output register)
        bus.out_ready = 1'b0;
        acc0 = n_acc;
        for (int i = 0; i < 20; i++) begin
            drive_op(1'b1, (i % 2) == 0, 32'h100 + 32'(4 * ((i / 2) % 8)),
                     32'hF000_0000 + 32'(i), 16'h0100 + 16'(i), 4'(i));
            cycle();
        end
        check("full_accepted", 32'(n_acc - acc0), 32'd17);
        check("full_count", 32'(bus.count_out), 32'd16);
        check("full_stall", 32'(bus.stall_out), 32'd1);
        check("full_out_valid", 32'(bus.out_valid), 32'd1);
        n_resp = 0;
        drain("full");
        check("full_responses", 32'(n_resp), 32'd17);

        // Simultaneous issue and enqueue while full
        bus.out_ready = 1'b0;
        for (int i = 0; i < 40 && bus.count_out != 5'd16; i++) begin
            drive_op(1'b1, (i % 2) == 0, 32'h120 + 32'(4 * ((i / 2) % 4)),
                     32'hC000_0000 + 32'(i), 16'h0200 + 16'(i), 4'(i));
            cycle();
        end
        drive_op(1'b1, 1'b1, 32'h13C, 32'h5555_AAAA, 16'h0FFF, 4'hF);
        bus.out_ready = 1'b1;
        #1;
        check("simul_in_ready", 32'(bus.in_ready), 32'd0);
        acc0 = n_acc;
        cycle();
        check("simul_not_accepted", 32'(n_acc - acc0), 32'd0);
        check("simul_count", 32'(bus.count_out), 32'd15);
        drain("simul");

        // Wrap: 100 ops, alternating store/load over 8 addresses, random backpressure
        n_resp = 0;
        k = 0;
        for (int c = 0; c < 3000 && k < 100; c++) begin
            drive_op(1'b1, (k % 2) == 0, 32'h180 + 32'(4 * ((k / 2) % 8)),
                     32'hA500_0000 + 32'(k * 7), 16'h0300 + 16'(k), 4'(k));
            bus.out_ready = 1'($urandom_range(0, 1));
            acc0 = n_acc;
            cycle();
            if (n_acc != acc0) k++;
        end
        check("wrap_ops_accepted", 32'(k), 32'd100);
        drain("wrap");
        check("wrap_responses", 32'(n_resp), 32'd100);

        // Flush: a load in the output register, stores to 0x44 queued behind it
        bus.out_ready = 1'b0;
        drive_op(1'b1, 1'b0, 32'h40, 32'h0, 16'h0400, 4'd0);
        @(posedge clk);
        #1;
        for (int i = 1; i < 5; i++) begin
            drive_op(1'b1, 1'b1, 32'h44, 32'hBAD0_0000 + 32'(i), 16'h0400 + 16'(i), 4'(i));
            @(posedge clk);
            #1;
        end
        check("flush_pre_count", 32'(bus.count_out), 32'd4);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        drive_op(1'b1, 1'b1, 32'h44, 32'hBAD0_00FF, 16'h04FF, 4'hE);
        #1;
        check("flush_mem_rw", 32'(bus.mem_rw), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_count", 32'(bus.count_out), 32'd0);
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        drive_op(1'b1, 1'b0, 32'h44, 32'h0, 16'h0099, 4'd9);
        @(posedge clk);
        #1;
        check("post_flush_n_valid", 32'(bus.out_valid), 32'd0);
        check("post_flush_n_count", 32'(bus.count_out), 32'd1);
        drive_op(1'b0, 1'b0, '0, '0, '0, '0);
        @(posedge clk);
        #1;
        check("post_flush_valid", 32'(bus.out_valid), 32'd1);
        check("post_flush_data", bus.data_out, 32'h12345678);
        check("post_flush_z", 32'(bus.z_out), 32'd9);
        check("post_flush_cntrl", 32'(bus.cntrl_out), 32'h0099);
        @(posedge clk);
        #1;
        check("post_flush_retired", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset in the middle of traffic
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_op(1'b1, 1'b1, 32'h1C0, 32'h7700_0000 + 32'(i), 16'h0500, 4'(i));
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b1;
        drive_op(1'b0, 1'b0, '0, '0, '0, '0);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
